// File: rtl/uart_tx_pkg.sv
// Shared UART transmit definitions: parity codes and the one-hot frame FSM states.
package uart_tx_pkg;

  localparam int unsigned UART_CHECK_NONE = 0;
  localparam int unsigned UART_CHECK_ODD  = 1;
  localparam int unsigned UART_CHECK_EVEN = 2;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bits; one line bit per clock.
// All outputs are registered and computed from the next-state values.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned P_UART_DATA_WIDTH = 8,
  parameter int unsigned P_UART_CHECK_ON   = 1,
  parameter int unsigned P_UART_STOP_WIDTH = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
  input  logic                         i_user_tx_valid,
  output logic                         o_user_tx_ready,
  output logic                         o_uart_tx,
  output logic                         o_uart_tx_busy
);

  localparam int unsigned W          = P_UART_DATA_WIDTH;
  localparam int unsigned CNT_W      = $clog2(W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(W - 1);
  localparam logic [1:0]       LAST_STOP = 2'(P_UART_STOP_WIDTH - 1);
  localparam bit HAS_PARITY = (P_UART_CHECK_ON != UART_CHECK_NONE);
  localparam bit EVEN_PAR   = (P_UART_CHECK_ON == UART_CHECK_EVEN);

  function automatic logic parity_bit(input logic [W-1:0] d);
    return EVEN_PAR ? (^d) : (~^d);
  endfunction

  tx_state_e        state_q, state_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [1:0]       stop_cnt_q, stop_cnt_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             fire_c;

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; line/ready/busy are derived from the state being entered
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    tx_d       = 1'b1;
    fire_c     = i_user_tx_valid && ready_q;

    unique case (state_q)
      ST_IDLE: begin
        if (fire_c) begin
          state_d = ST_START;
          shift_d = i_user_tx_data;
          par_d   = parity_bit(i_user_tx_data);
        end
      end
      ST_START: begin
        state_d   = ST_DATA;
        bit_cnt_d = '0;
      end
      ST_DATA: begin
        shift_d = shift_q >> 1;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d  = '0;
          stop_cnt_d = '0;
          state_d    = HAS_PARITY ? ST_PARITY : ST_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        state_d    = ST_STOP;
        stop_cnt_d = '0;
      end
      ST_STOP: begin
        if (stop_cnt_q == LAST_STOP) begin
          stop_cnt_d = '0;
          if (fire_c) begin
            state_d = ST_START;
            shift_d = i_user_tx_data;
            par_d   = parity_bit(i_user_tx_data);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          stop_cnt_d = stop_cnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // shift_d[0] is the bit for the data slot being entered (unshifted on START->DATA)
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase

    ready_d = (state_d == ST_IDLE) || ((state_d == ST_STOP) && (stop_cnt_d == LAST_STOP));
    busy_d  = (state_d != ST_IDLE);
  end

  assign o_uart_tx       = tx_q;
  assign o_user_tx_ready = ready_q;
  assign o_uart_tx_busy  = busy_q;

endmodule
